// File: rtl/fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader
// Purpose  : Drains an ff_fifo_* pop port into a registered valid/ready stream
//            through a 2-entry head/skid buffer. Define FIFO_STREAM_READER_LAST_EN
//            to enable out_last packet framing every PKT_LEN words.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
    parameter int WIDTH   = 5,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_read_data,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    // State encoding equals the number of buffered words.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             w_pop;
    logic             w_take;

    // Pop depends only on registered occupancy, never on out_ready.
    assign w_pop     = !rst && !fifo_empty && (state_q != S_TWO);
    assign w_take    = (state_q != S_EMPTY) && out_ready;
    assign fifo_pop  = w_pop;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = buf0_q;

    always_comb begin
        state_d = state_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            S_EMPTY: begin
                if (w_pop) begin
                    buf0_d  = fifo_read_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (w_pop && !w_take) begin
                    buf1_d  = fifo_read_data;
                    state_d = S_TWO;
                end else if (w_pop && w_take) begin
                    buf0_d  = fifo_read_data;
                end else if (w_take) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_take) begin
                    buf0_d  = buf1_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer contents are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int c_WCNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(PKT_LEN - 1);

    logic [c_WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (w_take) begin
            wcnt_d = (wcnt_q == c_WCNT_MAX) ? '0 : wcnt_q + c_WCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign out_last = out_valid && (wcnt_q == c_WCNT_MAX);
`else
    if (PKT_LEN >= 1) begin : g_last_tied
        assign out_last = 1'b0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader with a queue-based
//            FIFO and reader model, directed tables and random traffic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_stream_reader;

    localparam int WIDTH     = 5;
    localparam int PKT_LEN   = 4;
    localparam int FIFO_DEPTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] fifo_read_data;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    fifo_stream_reader #(
        .WIDTH   (WIDTH),
        .PKT_LEN (PKT_LEN)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_read_data (fifo_read_data),
        .fifo_empty     (fifo_empty),
        .fifo_pop       (fifo_pop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fq models the attached FIFO; mq holds the words the reader owns (head first).
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] mq[$];
    int               pk;
    int               n_cmp;
    int               n_bad;
    int               n_pops;
    int               n_takes;
    int               n_lasts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance at posedge.
    task automatic cycle(input logic r, input logic push, input logic [WIDTH-1:0] pd,
                         input logic rdy, output logic o_pop, output logic o_valid,
                         output logic [WIDTH-1:0] o_data);
        logic exp_pop;
        logic exp_valid;
        logic exp_last;
        logic take;
        rst        = r;
        out_ready  = rdy;
        fifo_empty = (fq.size() == 0);
        fifo_read_data = fifo_empty ? WIDTH'($urandom) : fq[0];
        #1;
        o_pop   = fifo_pop;
        o_valid = out_valid;
        o_data  = out_data;
        exp_pop   = !r && (fq.size() != 0) && (mq.size() < 2);
        exp_valid = (mq.size() != 0);
`ifdef FIFO_STREAM_READER_LAST_EN
        exp_last  = exp_valid && (pk == PKT_LEN - 1);
`else
        exp_last  = 1'b0;
`endif
        chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
        if (!r) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid) chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("out_last", {31'd0, out_last}, {31'd0, exp_last});
        end
        if (fifo_pop) n_pops++;
        if (!r && out_valid && rdy) begin
            n_takes++;
            if (out_last) n_lasts++;
        end
        take = !r && exp_valid && rdy;
        @(posedge clk);
        if (r) begin
            fq.delete();
            mq.delete();
            pk = 0;
        end else begin
            if (take) begin
                void'(mq.pop_front());
                pk = (pk == PKT_LEN - 1) ? 0 : pk + 1;
            end
            if (exp_pop) mq.push_back(fq.pop_front());
            if (push && fq.size() < FIFO_DEPTH) fq.push_back(pd);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        logic p, v;
        logic [WIDTH-1:0] d;
        int i;
        i = 0;
        while ((fq.size() != 0 || mq.size() != 0) && i < bound) begin
            cycle(1'b0, 1'b0, '0, 1'b1, p, v, d);
            i++;
        end
        chk("drain_timeout", 32'(i < bound), 32'd1);
    endtask

    typedef struct {
        logic             r;
        logic             push;
        logic [WIDTH-1:0] pd;
        logic             rdy;
        logic             e_pop;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic             p, v;
        logic [WIDTH-1:0] d;
        int               first_v, last_t, k, bad_len;

        vecs[0]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00};
        vecs[1]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00};
        vecs[2]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00};
        vecs[3]  = '{1'b0, 1'b1, 5'h15, 1'b1, 1'b0, 1'b0, 5'h00};
        vecs[4]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 5'h00};
        vecs[5]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h15};
        vecs[6]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00};
        vecs[7]  = '{1'b0, 1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 5'h00};
        vecs[8]  = '{1'b0, 1'b1, 5'h02, 1'b0, 1'b1, 1'b0, 5'h00};
        vecs[9]  = '{1'b0, 1'b1, 5'h03, 1'b0, 1'b1, 1'b1, 5'h01};
        vecs[10] = '{1'b0, 1'b1, 5'h04, 1'b0, 1'b0, 1'b1, 5'h01};
        vecs[11] = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 5'h01};
        vecs[12] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h01};
        vecs[13] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 5'h02};
        vecs[14] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 5'h03};
        vecs[15] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 5'h04};
        vecs[16] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 5'h00};

        n_cmp = 0; n_bad = 0; pk = 0;
        n_pops = 0; n_takes = 0; n_lasts = 0;
        rst = 1'b1; out_ready = 1'b0; fifo_empty = 1'b1; fifo_read_data = '0;

        // Reset, then idle with the FIFO empty and out_ready high.
        cycle(1'b1, 1'b0, '0, 1'b1, p, v, d);
        cycle(1'b1, 1'b0, '0, 1'b1, p, v, d);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1, p, v, d);
        chk("idle_pops", 32'(n_pops), 32'd0);

        // Directed table: single-word latency, then backpressure with skid.
        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].r, vecs[i].push, vecs[i].pd, vecs[i].rdy, p, v, d);
            chk($sformatf("vec%0d_pop", i), {31'd0, p}, {31'd0, vecs[i].e_pop});
            chk($sformatf("vec%0d_valid", i), {31'd0, v}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].e_data));
        end

        // Back-to-back 0x01..0x08 with out_ready=1: eight consecutive valid cycles.
        n_lasts = 0; first_v = -1; last_t = -1;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, i < 8, WIDTH'(i + 1), 1'b1, p, v, d);
            if (v && first_v < 0) first_v = i;
            if (v) last_t = i;
        end
        chk("b2b_first", 32'(first_v), 32'd2);
        chk("b2b_span", 32'(last_t - first_v + 1), 32'd8);
`ifdef FIFO_STREAM_READER_LAST_EN
        chk("b2b_lasts", 32'(n_lasts), 32'd2);
`else
        chk("b2b_lasts", 32'(n_lasts), 32'd0);
`endif

        // Preloaded 0x01..0x06, out_ready low for 5 cycles: only two pops.
        for (int i = 1; i <= 6; i++) fq.push_back(WIDTH'(i));
        n_pops = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0, p, v, d);
        chk("bp_pops", 32'(n_pops), 32'd2);
        chk("bp_hold", 32'(d), 32'h01);
        bad_len = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, p, v, d);
            if (!v || d != WIDTH'(i + 1)) bad_len++;
        end
        chk("bp_release_bubbles", 32'(bad_len), 32'd0);

        // Toggling out_ready across a 0x0A..0x11 stream.
        n_takes = 0;
        for (int i = 0; i < 30; i++) cycle(1'b0, i < 8, WIDTH'(8'h0A + i), i[0] == 1'b0, p, v, d);
        chk("toggle_takes", 32'(n_takes), 32'd8);

        // Mid-stream reset after two delivered words.
        n_takes = 0; k = 0;
        while (n_takes < 2 && k < 20) begin
            cycle(1'b0, k < 8, WIDTH'(k + 1), 1'b1, p, v, d);
            k++;
        end
        chk("rst_wait", 32'(n_takes), 32'd2);
        cycle(1'b1, 1'b0, '0, 1'b1, p, v, d);
        cycle(1'b0, 1'b0, '0, 1'b1, p, v, d);
        chk("rst_valid", {31'd0, v}, 32'd0);
        chk("rst_pop", {31'd0, p}, 32'd0);
        n_lasts = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, WIDTH'(5'h1C + i), 1'b1, p, v, d);
        drain(20);
`ifdef FIFO_STREAM_READER_LAST_EN
        chk("rst_lasts", 32'(n_lasts), 32'd1);
`else
        chk("rst_lasts", 32'(n_lasts), 32'd0);
`endif

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                  WIDTH'($urandom), $urandom_range(0, 3) != 0, p, v, d);
        end
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
